// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter front end.
//   state_e           : button-control FSM states
//   DEF_*             : default timing constants (clock cycles)
//   DATA_W            : width of the downstream saturating counter
package counter_pkg;

   localparam int unsigned DATA_W = 8;

   localparam logic [15:0] DEF_DEBOUNCE_CYCLES = 16'd50000;
   localparam logic [23:0] DEF_REPEAT_DELAY    = 24'd5000000;
   localparam logic [23:0] DEF_REPEAT_RATE     = 24'd1000000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DELAY,
      ST_REPEAT,
      ST_LOCK
   } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Synchroniser, debouncer and rising-edge detector for one push button.
//   clk, rst : system clock, async active-high reset
//   btn_raw  : raw asynchronous button input
//   level    : debounced level, registered so it lines up with press
//   press    : one-cycle strobe on a debounced rising edge
module btn_debounce
   import counter_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic level,
   output logic press
);

   logic        sync1_q, sync1_d;
   logic        sync2_q, sync2_d;
   logic        deb_q, deb_d;
   logic [15:0] cnt_q, cnt_d;
   logic        lvl_q, lvl_d;
   logic        press_q, press_d;

   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
      deb_d   = deb_q;
      cnt_d   = '0;
      if (sync2_q != deb_q) begin
         if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
            deb_d = ~deb_q;
         end else begin
            cnt_d = cnt_q + 16'd1;
         end
      end
      // level and press are both taken from deb_q so they become valid together
      lvl_d   = deb_q;
      press_d = deb_q & ~lvl_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         deb_q   <= 1'b0;
         cnt_q   <= '0;
         lvl_q   <= 1'b0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
         lvl_q   <= lvl_d;
         press_q <= press_d;
      end
   end

   assign level = lvl_q;
   assign press = press_q;

endmodule

// File: rtl/counter_btn_ctrl.sv
// Push-button front end for the 8-bit saturating up/down counter.
// Turns increment/decrement buttons into one step per press with
// hold-to-auto-repeat; pressing both buttons locks out stepping.
//   clk, rst         : system clock, async active-high reset
//   btn_inc, btn_dec : raw buttons, asynchronous, active-high
//   en               : one-cycle step strobe to the counter
//   up               : step direction (1 = increment), changes only with en
//   busy             : FSM is not idle
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_IDLE   | waiting for a press on a single button
// ST_DELAY  | first step issued, waiting REPEAT_DELAY before repeat
// ST_REPEAT | auto-repeating every REPEAT_RATE cycles
// ST_LOCK   | both buttons involved, no steps until both released
module counter_btn_ctrl
   import counter_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter logic [23:0] REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter logic [23:0] REPEAT_RATE     = DEF_REPEAT_RATE
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_inc,
   input  logic btn_dec,
   output logic en,
   output logic up,
   output logic busy
);

   logic lvl_inc, lvl_dec, press_inc, press_dec;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_inc (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_inc),
      .level   (lvl_inc),
      .press   (press_inc)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dec (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_dec),
      .level   (lvl_dec),
      .press   (press_dec)
   );

   state_e      state_q, state_d;
   logic [23:0] timer_q, timer_d;
   logic        en_q, en_d;
   logic        up_q, up_d;
   logic        own_lvl, other_lvl;

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      en_d      = 1'b0;
      up_d      = up_q;
      // up_q remembers which button started the current hold
      own_lvl   = up_q ? lvl_inc : lvl_dec;
      other_lvl = up_q ? lvl_dec : lvl_inc;
      case (state_q)
         ST_IDLE: begin
            if (press_inc && press_dec) begin
               state_d = ST_LOCK;
            end else if (press_inc && !lvl_dec) begin
               en_d    = 1'b1;
               up_d    = 1'b1;
               timer_d = REPEAT_DELAY - 24'd1;
               state_d = ST_DELAY;
            end else if (press_dec && !lvl_inc) begin
               en_d    = 1'b1;
               up_d    = 1'b0;
               timer_d = REPEAT_DELAY - 24'd1;
               state_d = ST_DELAY;
            end
         end
         ST_DELAY, ST_REPEAT: begin
            // exits win over a due timer step
            if (other_lvl) begin
               state_d = ST_LOCK;
            end else if (!own_lvl) begin
               state_d = ST_IDLE;
            end else if (timer_q == 24'd0) begin
               en_d    = 1'b1;
               timer_d = REPEAT_RATE - 24'd1;
               state_d = ST_REPEAT;
            end else begin
               timer_d = timer_q - 24'd1;
            end
         end
         ST_LOCK: begin
            if (!lvl_inc && !lvl_dec) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         en_q    <= 1'b0;
         up_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         en_q    <= en_d;
         up_q    <= up_d;
      end
   end

   assign en   = en_q;
   assign up   = up_q;
   assign busy = (state_q != ST_IDLE);

endmodule
